// File: rtl/rfft_ctrl_if.sv
// Handshake and FFT-core bus between rfft_ctrl (master) and its environment (slave).
interface rfft_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               Start;
  logic               Tf_load;
  logic               Busy;
  logic               Err;
  logic               Tf_valid;
  logic               Tf_ready;
  logic [2*WIDTH-1:0] Tf_data;
  logic               S_valid;
  logic               S_ready;
  logic [4*WIDTH-1:0] S_data;
  logic               M_valid;
  logic               M_ready;
  logic [4*WIDTH-1:0] M_data;
  logic               M_last;
  logic               Input;
  logic               Write;
  logic               Tf_we;
  logic [5:0]         Addr;
  logic [7:0]         Addr_T;
  logic [WIDTH-1:0]   Din0, Din1, Din2, Din3;
  logic [2*WIDTH-1:0] Tf_in;
  logic               Done;
  logic [WIDTH-1:0]   Dout0, Dout1, Dout2, Dout3;

  modport master (
    input  Start, Tf_load, Tf_valid, Tf_data, S_valid, S_data, M_ready,
           Done, Dout0, Dout1, Dout2, Dout3,
    output Busy, Err, Tf_ready, S_ready, M_valid, M_data, M_last,
           Input, Write, Tf_we, Addr, Addr_T, Din0, Din1, Din2, Din3, Tf_in
  );

  modport slave (
    output Start, Tf_load, Tf_valid, Tf_data, S_valid, S_data, M_ready,
           Done, Dout0, Dout1, Dout2, Dout3,
    input  Busy, Err, Tf_ready, S_ready, M_valid, M_data, M_last,
           Input, Write, Tf_we, Addr, Addr_T, Din0, Din1, Din2, Din3, Tf_in
  );
endinterface

// File: rtl/rfft_ctrl.sv
// Sequencer for a 64-beat radix-4 FFT core: twiddle load, sample load, run, buffered readout.
// Optional RUN watchdog compiled in with macro RFFT_CTRL_WATCHDOG_EN.
module rfft_ctrl #(
  parameter int WIDTH    = 32,
  parameter int TF_DEPTH = 256,
  parameter int TO_LIMIT = 1023
) (
  input  logic         Clk,
  input  logic         Reset_n,
  rfft_ctrl_if.master  bus
);

  typedef enum logic [2:0] {IDLE, LOAD_TF, LOAD, RUN, READ} state_t;

  state_t             state_reg;
  logic [7:0]         tf_cnt_reg;
  logic [5:0]         beat_cnt_reg;
  logic [5:0]         rd_cnt_reg;
  logic [5:0]         out_cnt_reg;
  logic               rd_done_reg;
  logic               rd_pend_reg;
  logic               busy_reg;
  logic [4*WIDTH-1:0] fifo_mem [2];
  logic               wr_ptr_reg;
  logic               rd_ptr_reg;
  logic [1:0]         fifo_cnt_reg;

  logic tf_hs, s_hs, rd_issue, push, pop, m_valid, wd_expire;

  assign tf_hs    = (state_reg == LOAD_TF) && bus.Tf_valid;
  assign s_hs     = (state_reg == LOAD) && bus.S_valid;
  assign m_valid  = (fifo_cnt_reg != 2'd0);
  assign pop      = m_valid && bus.M_ready;
  assign push     = rd_pend_reg;
  // Reads in flight count against the buffer so a stalled consumer can never overflow it
  assign rd_issue = (state_reg == READ) && !rd_done_reg &&
                    ((fifo_cnt_reg + 2'(rd_pend_reg)) < 2'd2);

`ifdef RFFT_CTRL_WATCHDOG_EN
  logic [9:0] wd_cnt_reg;
  logic       err_reg;

  assign wd_expire = (state_reg == RUN) && !bus.Done && (wd_cnt_reg == 10'(TO_LIMIT - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wd_cnt_reg <= 10'd0;
      err_reg    <= 1'b0;
    end else begin
      if ((state_reg == IDLE) && bus.Start)
        err_reg <= 1'b0;
      else if (wd_expire)
        err_reg <= 1'b1;
      if ((state_reg == RUN) && !wd_expire)
        wd_cnt_reg <= wd_cnt_reg + 10'd1;
      else
        wd_cnt_reg <= 10'd0;
    end
  end

  assign bus.Err = err_reg;
`else
  assign wd_expire = 1'b0;
  assign bus.Err   = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg    <= IDLE;
      tf_cnt_reg   <= 8'd0;
      beat_cnt_reg <= 6'd0;
      rd_cnt_reg   <= 6'd0;
      out_cnt_reg  <= 6'd0;
      rd_done_reg  <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.Start) begin
            busy_reg     <= 1'b1;
            tf_cnt_reg   <= 8'd0;
            beat_cnt_reg <= 6'd0;
            state_reg    <= bus.Tf_load ? LOAD_TF : LOAD;
          end
        end
        LOAD_TF: begin
          if (tf_hs) begin
            if (tf_cnt_reg == 8'(TF_DEPTH - 1)) begin
              tf_cnt_reg <= 8'd0;
              state_reg  <= LOAD;
            end else begin
              tf_cnt_reg <= tf_cnt_reg + 8'd1;
            end
          end
        end
        LOAD: begin
          if (s_hs) begin
            if (beat_cnt_reg == 6'd63) begin
              beat_cnt_reg <= 6'd0;
              state_reg    <= RUN;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 6'd1;
            end
          end
        end
        RUN: begin
          if (bus.Done) begin
            rd_cnt_reg  <= 6'd0;
            rd_done_reg <= 1'b0;
            out_cnt_reg <= 6'd0;
            state_reg   <= READ;
          end else if (wd_expire) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        READ: begin
          // Read address parks on 63 once the last read is out; rd_done blocks re-issue
          if (rd_issue) begin
            if (rd_cnt_reg == 6'd63)
              rd_done_reg <= 1'b1;
            else
              rd_cnt_reg <= rd_cnt_reg + 6'd1;
          end
          if (pop) begin
            if (out_cnt_reg == 6'd63) begin
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end else begin
              out_cnt_reg <= out_cnt_reg + 6'd1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_pend_reg  <= 1'b0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      fifo_cnt_reg <= 2'd0;
    end else begin
      rd_pend_reg  <= rd_issue;
      if (push)
        wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)
        rd_ptr_reg <= ~rd_ptr_reg;
      fifo_cnt_reg <= fifo_cnt_reg + 2'(push) - 2'(pop);
    end
  end

  // Core output arrives one cycle after its address, so the capture rides on rd_pend
  always_ff @(posedge Clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= {bus.Dout3, bus.Dout2, bus.Dout1, bus.Dout0};
  end

  assign bus.Busy     = busy_reg;
  assign bus.Input    = (state_reg != RUN);
  assign bus.Tf_ready = (state_reg == LOAD_TF);
  assign bus.Tf_we    = tf_hs;
  assign bus.Addr_T   = (state_reg == LOAD_TF) ? tf_cnt_reg : 8'd0;
  assign bus.Tf_in    = bus.Tf_data;
  assign bus.S_ready  = (state_reg == LOAD);
  assign bus.Write    = s_hs;
  assign bus.Addr     = (state_reg == LOAD) ? beat_cnt_reg :
                        (state_reg == READ) ? rd_cnt_reg : 6'd0;
  assign bus.Din0     = bus.S_data[0*WIDTH +: WIDTH];
  assign bus.Din1     = bus.S_data[1*WIDTH +: WIDTH];
  assign bus.Din2     = bus.S_data[2*WIDTH +: WIDTH];
  assign bus.Din3     = bus.S_data[3*WIDTH +: WIDTH];
  assign bus.M_valid  = m_valid;
  assign bus.M_data   = fifo_mem[rd_ptr_reg];
  assign bus.M_last   = m_valid && (out_cnt_reg == 6'd63);

endmodule

// File: tb/tb_rfft_ctrl.sv
// Self-checking bench for rfft_ctrl: identity FFT-core model, randomized streams, queue scoreboard.
module tb_rfft_ctrl;
  localparam int W = 32;
  localparam logic [22:0] RESET_VEC = {9'b000001000, 6'd0, 8'd0};

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   done_en = 1'b1;
  int   run_cnt = 0;
  int   tf_ready_seen = 0;

  logic [2*W-1:0] tf_sent[$];
  logic [2*W-1:0] tf_data_log[$];
  int             tf_addr_log[$];
  logic [4*W-1:0] s_sent[$];
  logic [4*W-1:0] wr_data_log[$];
  int             wr_addr_log[$];
  int             wr_cyc_log[$];
  logic [4*W-1:0] out_log[$];
  bit             last_log[$];
  logic [4*W-1:0] core_mem [64];

  rfft_ctrl_if #(.WIDTH(W)) bus ();

  rfft_ctrl #(.WIDTH(W), .TF_DEPTH(256), .TO_LIMIT(1023)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  // Identity core: results equal the stored samples; Done 460 cycles after Input falls
  always @(posedge Clk) begin
    if (bus.Write) core_mem[bus.Addr] <= {bus.Din3, bus.Din2, bus.Din1, bus.Din0};
    {bus.Dout3, bus.Dout2, bus.Dout1, bus.Dout0} <= core_mem[bus.Addr];
    if (bus.Input === 1'b1) begin
      run_cnt  <= 0;
      bus.Done <= 1'b0;
    end else begin
      run_cnt <= run_cnt + 1;
      if (done_en && run_cnt == 459) bus.Done <= 1'b1;
    end
    if (bus.Tf_ready === 1'b1) tf_ready_seen++;
    if (bus.Tf_we === 1'b1) begin
      tf_addr_log.push_back(int'(bus.Addr_T));
      tf_data_log.push_back(bus.Tf_in);
    end
    if (bus.Write === 1'b1) begin
      wr_addr_log.push_back(int'(bus.Addr));
      wr_data_log.push_back({bus.Din3, bus.Din2, bus.Din1, bus.Din0});
      wr_cyc_log.push_back(cyc);
    end
    if (bus.M_valid === 1'b1 && bus.M_ready === 1'b1) begin
      out_log.push_back(bus.M_data);
      last_log.push_back(bus.M_last);
    end
    cyc++;
  end

  function automatic logic [22:0] obs_vec();
    return {bus.Busy, bus.Err, bus.Tf_ready, bus.S_ready, bus.M_valid, bus.Input,
            bus.Write, bus.Tf_we, bus.M_last, bus.Addr, bus.Addr_T};
  endfunction

  function automatic int result_errors();
    int e = 0;
    if (out_log.size() != 64 || s_sent.size() != 64) e++;
    for (int k = 0; k < out_log.size() && k < s_sent.size(); k++)
      if (out_log[k] !== s_sent[k] || last_log[k] !== (k == 63)) e++;
    return e;
  endfunction

  function automatic int write_errors();
    int e = 0;
    if (wr_addr_log.size() != 64 || s_sent.size() != 64) e++;
    for (int k = 0; k < wr_addr_log.size() && k < s_sent.size(); k++)
      if (wr_addr_log[k] != k || wr_data_log[k] !== s_sent[k]) e++;
    return e;
  endfunction

  task automatic clear_logs();
    tf_sent.delete(); tf_data_log.delete(); tf_addr_log.delete();
    s_sent.delete(); wr_data_log.delete(); wr_addr_log.delete(); wr_cyc_log.delete();
    out_log.delete(); last_log.delete();
    tf_ready_seen = 0;
  endtask

  task automatic start_transform(input bit tl);
    @(negedge Clk);
    bus.Start = 1'b1; bus.Tf_load = tl;
    @(negedge Clk);
    bus.Start = 1'b0; bus.Tf_load = 1'b0;
  endtask

  task automatic drive_tf();
    int n = 0;
    int g = 0;
    while (n < 256 && g < 3000) begin
      @(negedge Clk);
      bus.Tf_valid = ($urandom_range(0, 3) != 0);
      bus.Tf_data  = {$urandom, $urandom};
      #1;
      if (bus.Tf_valid && bus.Tf_ready === 1'b1) begin tf_sent.push_back(bus.Tf_data); n++; end
      g++;
    end
    @(negedge Clk);
    bus.Tf_valid = 1'b0;
    checks++;
    if (n !== 256) begin failures++; $display("FAIL tf_stream got=%0d beats want=256", n); end
  endtask

  // mode 0: valid every cycle, 1: toggle 1,0, 2: random; ign_at pulses Start (ignored) at that beat
  task automatic drive_samples(input int mode, input int ign_at);
    int n = 0;
    int g = 0;
    bit ph = 1'b1;
    bit v;
    while (n < 64 && g < 2000) begin
      @(negedge Clk);
      case (mode)
        0: v = 1'b1;
        1: begin v = ph; ph = !ph; end
        default: v = ($urandom_range(0, 1) == 1);
      endcase
      bus.S_valid = v;
      bus.S_data  = {$urandom, $urandom, $urandom, $urandom};
      bus.Start   = (n == ign_at);
      bus.Tf_load = 1'b1;
      #1;
      if (v && bus.S_ready === 1'b1) begin s_sent.push_back(bus.S_data); n++; end
      g++;
    end
    @(negedge Clk);
    bus.S_valid = 1'b0; bus.Start = 1'b0; bus.Tf_load = 1'b0;
    checks++;
    if (n !== 64) begin failures++; $display("FAIL sample_stream got=%0d beats want=64", n); end
  endtask

  task automatic read_all(input bit rand_ready);
    int g = 0;
    while (out_log.size() < 64 && g < 4000) begin
      @(negedge Clk);
      bus.M_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      g++;
    end
    @(negedge Clk);
    bus.M_ready = 1'b0;
    checks++;
    if (out_log.size() < 64) begin failures++; $display("FAIL read_phase got=%0d beats want=64", out_log.size()); end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if (obs_vec() !== RESET_VEC) begin failures++; $display("FAIL reset_outputs got=%h want=%h", obs_vec(), RESET_VEC); end
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    checks++;
    if (obs_vec() !== RESET_VEC) begin failures++; $display("FAIL idle_outputs got=%h want=%h", obs_vec(), RESET_VEC); end
    $display("test_reset done checks=%0d", checks);
  endtask

  task automatic test_tf_load();
    int e = 0;
    clear_logs();
    start_transform(1'b1);
    checks++;
    if (bus.Busy !== 1'b1) begin failures++; $display("FAIL busy_after_start got=%b want=1", bus.Busy); end
    drive_tf();
    drive_samples(2, -1);
    read_all(1'b1);
    if (tf_addr_log.size() != 256) e++;
    for (int k = 0; k < tf_addr_log.size() && k < tf_sent.size(); k++)
      if (tf_addr_log[k] != k || tf_data_log[k] !== tf_sent[k]) e++;
    checks++;
    if (e !== 0) begin failures++; $display("FAIL tf_writes got=%0d pulses errors=%0d want=256 in order", tf_addr_log.size(), e); end
    checks++;
    if (write_errors() !== 0) begin failures++; $display("FAIL tf_load_data_writes got=%0d errors want=0", write_errors()); end
    checks++;
    if (result_errors() !== 0) begin failures++; $display("FAIL tf_load_results got=%0d errors want=0", result_errors()); end
    checks++;
    if (bus.Busy !== 1'b0) begin failures++; $display("FAIL busy_after_read got=%b want=0", bus.Busy); end
    $display("test_tf_load done checks=%0d", checks);
  endtask

  task automatic test_toggle_load();
    int e = 0;
    int g = 0;
    int span;
    clear_logs();
    start_transform(1'b0);
    drive_samples(1, -1);
    checks++;
    if (tf_ready_seen !== 0 || tf_addr_log.size() !== 0) begin
      failures++; $display("FAIL no_load_tf got=%0d ready cycles %0d tf writes want=0", tf_ready_seen, tf_addr_log.size());
    end
    for (int k = 1; k < wr_addr_log.size(); k++)
      if (wr_addr_log[k] <= wr_addr_log[k-1]) e++;
    checks++;
    if (wr_addr_log.size() !== 64 || e !== 0) begin
      failures++; $display("FAIL toggle_writes got=%0d writes %0d non-increasing want=64,0", wr_addr_log.size(), e);
    end
    span = (wr_cyc_log.size() == 64) ? wr_cyc_log[63] - wr_cyc_log[0] : 0;
    checks++;
    if (span < 120 || span > 132) begin failures++; $display("FAIL toggle_span got=%0d cycles want=120..132", span); end
    while (bus.Done !== 1'b1 && g < 1000) begin @(negedge Clk); g++; end
    checks++;
    if (bus.Done !== 1'b1 || bus.Input !== 1'b0) begin
      failures++; $display("FAIL done_in_run got done=%b input=%b want 1,0", bus.Done, bus.Input);
    end
    @(negedge Clk);
    checks++;
    if (bus.Input !== 1'b1 || bus.Busy !== 1'b1) begin
      failures++; $display("FAIL read_entry got input=%b busy=%b want 1,1", bus.Input, bus.Busy);
    end
    read_all(1'b0);
    checks++;
    if (result_errors() !== 0) begin failures++; $display("FAIL toggle_results got=%0d errors want=0", result_errors()); end
    checks++;
    if (bus.Busy !== 1'b0) begin failures++; $display("FAIL busy_end got=%b want=0", bus.Busy); end
    $display("test_toggle_load done checks=%0d", checks);
  endtask

  task automatic test_read_stall();
    int g = 0;
    int o;
    int maxo = 0;
    int stalled = 0;
    bit moved = 1'b0;
    bit head_set = 1'b0;
    logic [4*W-1:0] head;
    clear_logs();
    start_transform(1'b0);
    drive_samples(0, -1);
    while (bus.Done !== 1'b1 && g < 1000) begin @(negedge Clk); g++; end
    g = 0;
    while (out_log.size() < 64 && g < 3000) begin
      @(negedge Clk);
      g++;
      if (bus.Busy === 1'b1) begin
        o = int'(bus.Addr) - out_log.size();
        if (o > maxo) maxo = o;
      end
      if (out_log.size() >= 20 && stalled < 20) begin
        if (bus.M_valid === 1'b1) begin
          if (!head_set) begin head = bus.M_data; head_set = 1'b1; end
          else if (bus.M_data !== head) moved = 1'b1;
        end
        if (stalled == 19) begin
          checks++;
          if (int'(bus.Addr) !== out_log.size() + 2 || bus.M_valid !== 1'b1) begin
            failures++; $display("FAIL stall_fill got addr=%0d valid=%b want addr=%0d valid=1", bus.Addr, bus.M_valid, out_log.size() + 2);
          end
        end
        bus.M_ready = 1'b0;
        stalled++;
      end else begin
        bus.M_ready = (stalled >= 20) ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
    end
    @(negedge Clk);
    bus.M_ready = 1'b0;
    checks++;
    if (moved !== 1'b0) begin failures++; $display("FAIL stall_data_stable got moved=%b want=0", moved); end
    checks++;
    if (maxo > 2) begin failures++; $display("FAIL outstanding got=%0d want<=2", maxo); end
    checks++;
    if (result_errors() !== 0) begin failures++; $display("FAIL stall_results got=%0d errors want=0", result_errors()); end
    $display("test_read_stall done checks=%0d", checks);
  endtask

  task automatic test_start_ignored();
    int g = 0;
    clear_logs();
    start_transform(1'b0);
    drive_samples(2, 10);
    while (bus.Input !== 1'b0 && g < 100) begin @(negedge Clk); g++; end
    bus.Start = 1'b1; bus.Tf_load = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0; bus.Tf_load = 1'b0;
    checks++;
    if (bus.Input !== 1'b0 || bus.Busy !== 1'b1 || bus.Tf_ready !== 1'b0) begin
      failures++; $display("FAIL start_in_run got input=%b busy=%b tf_ready=%b want 0,1,0", bus.Input, bus.Busy, bus.Tf_ready);
    end
    read_all(1'b1);
    checks++;
    if (tf_addr_log.size() !== 0 || write_errors() !== 0) begin
      failures++; $display("FAIL start_in_load got tf=%0d write errors=%0d want 0,0", tf_addr_log.size(), write_errors());
    end
    checks++;
    if (result_errors() !== 0) begin failures++; $display("FAIL start_ignored_results got=%0d errors want=0", result_errors()); end
    $display("test_start_ignored done checks=%0d", checks);
  endtask

  task automatic test_reset_midop();
    int g = 0;
    clear_logs();
    start_transform(1'b0);
    while (g < 500) begin
      @(negedge Clk);
      if (wr_addr_log.size() >= 30) break;
      bus.S_valid = 1'b1;
      bus.S_data  = {$urandom, $urandom, $urandom, $urandom};
      g++;
    end
    Reset_n = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== RESET_VEC) begin failures++; $display("FAIL midop_reset got=%h want=%h", obs_vec(), RESET_VEC); end
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (20) @(negedge Clk);
    checks++;
    if (wr_addr_log.size() !== 30 || bus.Busy !== 1'b0 || bus.S_ready !== 1'b0) begin
      failures++; $display("FAIL after_reset got writes=%0d busy=%b s_ready=%b want 30,0,0", wr_addr_log.size(), bus.Busy, bus.S_ready);
    end
    bus.S_valid = 1'b0;
    $display("test_reset_midop done checks=%0d", checks);
  endtask

`ifdef RFFT_CTRL_WATCHDOG_EN
  task automatic test_watchdog();
    int g = 0;
    int n = 0;
    clear_logs();
    done_en = 1'b0;
    start_transform(1'b0);
    drive_samples(0, -1);
    while (bus.Input !== 1'b0 && g < 100) begin @(negedge Clk); g++; end
    while (bus.Err !== 1'b1 && n < 1200) begin @(negedge Clk); n++; end
    checks++;
    if (n < 1021 || n > 1025) begin failures++; $display("FAIL watchdog_time got=%0d cycles want~1023", n); end
    checks++;
    if (bus.Busy !== 1'b0 || bus.Input !== 1'b1) begin
      failures++; $display("FAIL watchdog_idle got busy=%b input=%b want 0,1", bus.Busy, bus.Input);
    end
    done_en = 1'b1;
    clear_logs();
    start_transform(1'b0);
    checks++;
    if (bus.Err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b want=0", bus.Err); end
    drive_samples(0, -1);
    read_all(1'b1);
    checks++;
    if (result_errors() !== 0) begin failures++; $display("FAIL wd_recover_results got=%0d errors want=0", result_errors()); end
    $display("test_watchdog done checks=%0d", checks);
  endtask
`endif

  initial begin
    #700000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    bus.Start = 1'b0; bus.Tf_load = 1'b0;
    bus.Tf_valid = 1'b0; bus.Tf_data = '0;
    bus.S_valid = 1'b0; bus.S_data = '0;
    bus.M_ready = 1'b0;
    test_reset();
    test_tf_load();
    test_toggle_load();
    test_read_stall();
    test_start_ignored();
    test_reset_midop();
`ifdef RFFT_CTRL_WATCHDOG_EN
    test_watchdog();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
